// File: rtl/count_pulse_gen_if.sv
// Button-to-counter strobe bundle: raw button and enable in, strobe and debounced level out.
// No flow control; the consumer samples count_up every clock.
interface count_pulse_gen_if;
   logic btn_in;
   logic en;
   logic count_up;
   logic btn_level;

   modport master (
      output btn_in,
      output en,
      input  count_up,
      input  btn_level
   );

   modport slave (
      input  btn_in,
      input  en,
      output count_up,
      output btn_level
   );
endinterface

// File: rtl/count_pulse_gen.sv
// Debounced push-button to single-cycle count strobe with auto-repeat; press strobe DEB_CYCLES+2 clocks after btn_in settles.
// No backpressure: strobes gated off by en are dropped, never queued.
module count_pulse_gen #(
   parameter int unsigned DEB_CYCLES    = 4,
   parameter int unsigned REPEAT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             resetn,
   count_pulse_gen_if.slave bus
);
   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
   localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
   localparam bit          RPT_EN   = (REPEAT_CYCLES != 0);

   logic        r_sync1;
   logic        r_sync2;
   state_t      r_state;
   logic [7:0]  r_deb_cnt;
   logic [15:0] r_rpt_cnt;
   logic        r_count_up;
   logic        r_btn_level;
   logic        w_sync_in;

   assign w_sync_in     = r_sync2;
   assign bus.count_up  = r_count_up;
   assign bus.btn_level = r_btn_level;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_state     <= RELEASED;
         r_deb_cnt   <= 8'd0;
         r_rpt_cnt   <= 16'd0;
         r_count_up  <= 1'b0;
         r_btn_level <= 1'b0;
      end else begin
         r_sync1    <= bus.btn_in;
         r_sync2    <= r_sync1;
         r_count_up <= 1'b0;
         case (r_state)
            RELEASED: begin
               if (w_sync_in) begin
                  r_state   <= DEB_PRESS;
                  r_deb_cnt <= 8'd0;
               end
            end
            DEB_PRESS: begin
               if (!w_sync_in) begin
                  r_state <= RELEASED;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state     <= PRESSED;
                  r_btn_level <= 1'b1;
                  r_rpt_cnt   <= 16'd0;
                  r_count_up  <= bus.en;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 8'd1;
               end
            end
            PRESSED: begin
               if (!w_sync_in) begin
                  r_state   <= DEB_RELEASE;
                  r_deb_cnt <= 8'd0;
               end else if (RPT_EN) begin
                  if (r_rpt_cnt == RPT_LAST) begin
                     r_rpt_cnt  <= 16'd0;
                     r_count_up <= bus.en;
                  end else begin
                     r_rpt_cnt <= r_rpt_cnt + 16'd1;
                  end
               end
            end
            DEB_RELEASE: begin
               // rpt_cnt stays frozen here so a rejected release only delays the repeat phase
               if (w_sync_in) begin
                  r_state <= PRESSED;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state     <= RELEASED;
                  r_btn_level <= 1'b0;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 8'd1;
               end
            end
            default: r_state <= RELEASED;
         endcase
      end
   end
endmodule

// File: tb/tb_count_pulse_gen.sv
// Bench: two instances (defaults, and DEB_CYCLES=1/REPEAT_CYCLES=2) against a level/pending behavioural model.
module tb_count_pulse_gen;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   count_pulse_gen_if bus0();
   count_pulse_gen_if bus1();

   count_pulse_gen #(.DEB_CYCLES(4), .REPEAT_CYCLES(16)) dut0 (
      .clk(clk), .resetn(resetn), .bus(bus0)
   );
   count_pulse_gen #(.DEB_CYCLES(1), .REPEAT_CYCLES(2)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1)
   );

   int checks   = 0;
   int failures = 0;

   // Model: debounced level, whether a level change is pending, and the repeat phase.
   int md [2] = '{4, 1};
   int mr [2] = '{16, 2};
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_lvl [2];
   bit m_pend [2];
   bit m_pulse [2];
   int m_cnt [2];
   int m_phase [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_pend[k] = 0;
         m_pulse[k] = 0; m_cnt[k] = 0; m_phase[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input bit b, input bit e);
      bit s;
      s = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = b;
      m_pulse[k] = 0;
      if (!m_pend[k]) begin
         if (s != m_lvl[k]) begin
            m_pend[k] = 1;
            m_cnt[k]  = 0;
         end else if (m_lvl[k] && mr[k] != 0) begin
            m_phase[k]++;
            if (m_phase[k] == mr[k]) begin
               m_phase[k] = 0;
               m_pulse[k] = e;
            end
         end
      end else if (s == m_lvl[k]) begin
         m_pend[k] = 0;
      end else begin
         m_cnt[k]++;
         if (m_cnt[k] == md[k]) begin
            m_pend[k] = 0;
            m_lvl[k]  = s;
            if (s) begin
               m_phase[k] = 0;
               m_pulse[k] = e;
            end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick(input bit b, input bit e);
      bus0.btn_in = b; bus1.btn_in = b;
      bus0.en = e;     bus1.en = e;
      @(posedge clk);
      if (resetn) begin
         model_edge(0, b, e);
         model_edge(1, b, e);
      end
      @(negedge clk);
   endtask

   function automatic logic [3:0] obs();
      return {bus0.count_up, bus0.btn_level, bus1.count_up, bus1.btn_level};
   endfunction

   function automatic logic [3:0] expv();
      return {m_pulse[0], m_lvl[0], m_pulse[1], m_lvl[1]};
   endfunction

   task automatic test_reset();
      resetn = 0;
      bus0.btn_in = 1; bus1.btn_in = 1; bus0.en = 1; bus1.en = 1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state cyc=%0d got=%b exp=0000", i, obs());
         end
      end
      bus0.btn_in = 0; bus1.btn_in = 0;
      resetn = 1;
      for (int i = 0; i < 4; i++) tick(0, 1);
   endtask

   task automatic test_clean_press();
      int first = -1;
      int npulse = 0;
      for (int i = 0; i < 22; i++) begin
         tick(i < 10, 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL clean_press cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up) begin
            npulse++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (first !== 6 || npulse !== 1) begin
         failures++;
         $display("FAIL clean_press_timing got first=%0d n=%0d exp first=6 n=1", first, npulse);
      end
   endtask

   task automatic test_bounce();
      bit pat [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
      int seen = 0;
      for (int i = 0; i < 21; i++) begin
         tick(i < 9 ? pat[i] : 1'b0, 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL bounce cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up || bus0.btn_level) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL bounce_reject got active_cycles=%0d exp=0", seen);
      end
   endtask

   task automatic test_repeat();
      logic [2:0] ctr = 3'd0;
      int idx [$];
      for (int i = 0; i < 72; i++) begin
         tick(i < 60, 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL repeat cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up) begin
            ctr = ctr + 3'd1;
            idx.push_back(i);
         end
      end
      checks++;
      if (ctr !== 3'b100 || idx.size() != 4 || idx[0] != 6 || idx[1] != 22 || idx[2] != 38 || idx[3] != 54) begin
         failures++;
         $display("FAIL repeat_counter got=%b n=%0d exp=100 at 6,22,38,54", ctr, idx.size());
      end
   endtask

   task automatic test_glitch();
      int drops = 0;
      int idx [$];
      for (int i = 0; i < 74; i++) begin
         tick(!(i == 30 || i == 31 || i >= 62), 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL glitch cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (i >= 6 && i < 64 && !bus0.btn_level) drops++;
         if (bus0.count_up) idx.push_back(i);
      end
      // Two low samples plus the return edge freeze the phase for three clocks.
      checks++;
      if (drops !== 0 || idx.size() != 4 || idx[2] != 41 || idx[3] != 57) begin
         failures++;
         $display("FAIL glitch_hold got drops=%0d n=%0d exp drops=0 pulses 6,22,41,57", drops, idx.size());
      end
   endtask

   task automatic test_enable();
      int n_off = 0;
      int n_on = 0;
      int lvl_seen = 0;
      for (int i = 0; i < 37; i++) begin
         tick(i < 25, 0);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL enable_off cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up) n_off++;
         if (bus0.btn_level) lvl_seen++;
      end
      for (int i = 0; i < 22; i++) begin
         tick(i < 10, 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL enable_on cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up) n_on++;
      end
      checks++;
      if (n_off !== 0 || n_on !== 1 || lvl_seen == 0) begin
         failures++;
         $display("FAIL enable_gate got off=%0d on=%0d lvl=%0d exp off=0 on=1 lvl>0", n_off, n_on, lvl_seen);
      end
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      int first = -1;
      while (!bus0.count_up && guard < 20) begin
         tick(1, 1);
         guard++;
      end
      checks++;
      if (!bus0.count_up) begin
         failures++;
         $display("FAIL mid_reset_setup got no press pulse within 20 cycles");
      end
      resetn = 0;
      model_reset();
      #1;
      checks++;
      if (obs() !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset_async got=%b exp=0000", obs());
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) tick(1, 1);
      resetn = 1;
      for (int i = 0; i < 24; i++) begin
         tick(i < 12, 1);
         checks++;
         if (obs() !== expv()) begin
            failures++;
            $display("FAIL mid_reset cyc=%0d got=%b exp=%b", i, obs(), expv());
         end
         if (bus0.count_up && first < 0) first = i;
      end
      checks++;
      if (first !== 6) begin
         failures++;
         $display("FAIL mid_reset_repress got first=%0d exp=6", first);
      end
   endtask

   task automatic test_random();
      int cyc;
      bit lvl;
      int len;
      bit e;
      cyc = 0;
      while (cyc < 3000) begin
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
         for (int j = 0; j < len; j++) begin
            e = ($urandom_range(0, 7) != 0);
            tick(lvl, e);
            cyc++;
            checks++;
            if (obs() !== expv()) begin
               failures++;
               $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
         end
         if ($urandom_range(0, 99) == 0) begin
            resetn = 0;
            model_reset();
            #1;
            checks++;
            if (obs() !== expv()) begin
               failures++;
               $display("FAIL random_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            @(negedge clk);
            tick(lvl, 1);
            resetn = 1;
         end
      end
   endtask

   initial begin
      resetn = 0;
      bus0.btn_in = 0; bus1.btn_in = 0; bus0.en = 0; bus1.en = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat();
      test_glitch();
      test_enable();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
